// File: rtl/poly_horner_engine_pkg.sv
// Shared types for the Horner polynomial engine: FSM states and ALU opcodes.
package poly_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic {
    ALU_ADD = 1'b0,
    ALU_MUL = 1'b1
  } alu_op_t;

endpackage

// File: rtl/poly_horner_engine_alu.sv
// Shared add/multiply ALU for the Horner engine. With POLY_SAT_EN defined the
// result clamps to all-ones on overflow; otherwise it wraps and ovf stays 0.
module poly_alu
  import poly_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_t          op,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

`ifdef POLY_SAT_EN
  logic [2*WIDTH-1:0] wide;

  // Full-width result; the upper half only drives the overflow decision.
  always_comb begin
    if (op == ALU_MUL) wide = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    else               wide = {{WIDTH{1'b0}}, a} + {{WIDTH{1'b0}}, b};
    ovf    = |wide[2*WIDTH-1:WIDTH];
    result = ovf ? {WIDTH{1'b1}} : wide[WIDTH-1:0];
  end
`else
  always_comb begin
    if (op == ALU_MUL) result = a * b;
    else               result = a + b;
    ovf = 1'b0;
  end
`endif

endmodule

// File: rtl/poly_horner_engine.sv
// Horner-rule polynomial evaluator sharing one add/multiply ALU.
// Optional saturating arithmetic and overflow flag via POLY_SAT_EN.
//
// state | meaning
// LOAD  | accept coefficients c[DEGREE]..c[0], then x
// MUL   | acc <= acc * x
// ADD   | acc <= acc + coef[step]; finish when step reaches 0
// DONE  | present result until downstream accepts it
module poly_horner_engine
  import poly_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEGREE = 2,
  parameter int CNT_W  = $clog2(DEGREE + 2)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow
);

  state_t           state;
  logic [CNT_W-1:0] load_cnt;
  logic [CNT_W-1:0] step;
  logic [WIDTH-1:0] coef [DEGREE+1];
  logic [WIDTH-1:0] x_reg;
  logic [WIDTH-1:0] acc;
  logic             sticky;

  logic [WIDTH-1:0] coef_sel;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;
  logic             alu_ovf;
  alu_op_t          alu_op;

  // Loop-based select keeps the index width independent of DEGREE.
  always_comb begin
    coef_sel = '0;
    for (int i = 0; i <= DEGREE; i++) begin
      if (step == CNT_W'(i)) coef_sel = coef[i];
    end
  end

  assign alu_op = (state == MUL) ? ALU_MUL : ALU_ADD;
  assign alu_b  = (state == MUL) ? x_reg : coef_sel;

  poly_alu #(.WIDTH(WIDTH)) u_alu (
    .a      (acc),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_result),
    .ovf    (alu_ovf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LOAD;
      load_cnt  <= '0;
      step      <= '0;
      for (int i = 0; i <= DEGREE; i++) coef[i] <= '0;
      x_reg     <= '0;
      acc       <= '0;
      sticky    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          sticky <= 1'b0;
          if (in_valid && in_ready) begin
            if (load_cnt == CNT_W'(DEGREE + 1)) begin
              x_reg    <= in_data;
              acc      <= coef[DEGREE];
              step     <= CNT_W'(DEGREE - 1);
              load_cnt <= '0;
              in_ready <= 1'b0;
              state    <= MUL;
            end else begin
              // Word k lands in coef[DEGREE-k]: highest order arrives first.
              for (int i = 0; i <= DEGREE; i++) begin
                if (load_cnt == CNT_W'(DEGREE - i)) coef[i] <= in_data;
              end
              load_cnt <= load_cnt + 1'b1;
            end
          end
        end
        MUL: begin
          acc    <= alu_result;
          sticky <= sticky | alu_ovf;
          state  <= ADD;
        end
        ADD: begin
          acc    <= alu_result;
          sticky <= sticky | alu_ovf;
          if (step == '0) begin
            out_data  <= alu_result;
            overflow  <= sticky | alu_ovf;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            step  <= step - 1'b1;
            state <= MUL;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_horner_engine.sv
// Directed bench for poly_horner_engine: default (8-bit, degree 2) and a
// 16-bit degree-3 instance. Expectations follow POLY_SAT_EN when defined.
module tb_poly_horner_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;

  logic [15:0] d3_in_data;
  logic        d3_in_valid;
  logic        d3_in_ready;
  logic [15:0] d3_out_data;
  logic        d3_out_valid;
  logic        d3_out_ready;
  logic        d3_overflow;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef POLY_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  always #5 clk = ~clk;

  poly_horner_engine dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow)
  );

  poly_horner_engine #(.WIDTH(16), .DEGREE(3)) dut3 (
    .clk       (clk),
    .reset     (reset),
    .in_data   (d3_in_data),
    .in_valid  (d3_in_valid),
    .in_ready  (d3_in_ready),
    .out_data  (d3_out_data),
    .out_valid (d3_out_valid),
    .out_ready (d3_out_ready),
    .overflow  (d3_overflow)
  );

  typedef struct {
    logic [7:0] c2, c1, c0, x;
    logic [7:0] y_wrap, y_sat;
    logic       ovf_sat;
    int         max_gap;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the word transferred.
  task automatic send_word(input logic [7:0] w, input int gaps);
    int t;
    for (int g = 0; g < gaps; g++) begin
      in_valid = 1'b0;
      @(posedge clk); @(negedge clk);
    end
    in_data  = w;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); @(negedge clk);
      t++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic load_all(input logic [7:0] c2, c1, c0, x, input int max_gap);
    send_word(c2, $urandom_range(max_gap, 0));
    send_word(c1, $urandom_range(max_gap, 0));
    send_word(c0, $urandom_range(max_gap, 0));
    send_word(x,  $urandom_range(max_gap, 0));
  endtask

  task automatic eval(input string name, input logic [7:0] c2, c1, c0, x,
                      input logic [7:0] exp_y, input logic exp_ovf,
                      input int max_gap, input int hold);
    int lat;
    load_all(c2, c1, c0, x, max_gap);
    check({name, "_in_ready_busy"}, 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'd4);
    check({name, "_out_data"}, 32'(out_data), 32'(exp_y));
    check({name, "_overflow"}, 32'(overflow), 32'(exp_ovf));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); @(negedge clk);
      check({name, "_hold_data"}, 32'(out_data), 32'(exp_y));
      check({name, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      check({name, "_hold_valid"}, 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check({name, "_release_in_ready"}, 32'(in_ready), 32'd1);
    check({name, "_release_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    logic [15:0] d3_words[5];

    vecs[0] = '{c2:8'd2,   c1:8'd3,   c0:8'd4,   x:8'd5,   y_wrap:8'd69,  y_sat:8'd69,  ovf_sat:1'b0, max_gap:0};
    vecs[1] = '{c2:8'd10,  c1:8'd0,   c0:8'd0,   x:8'd10,  y_wrap:8'd232, y_sat:8'd255, ovf_sat:1'b1, max_gap:0};
    vecs[2] = '{c2:8'd0,   c1:8'd0,   c0:8'd0,   x:8'd0,   y_wrap:8'd0,   y_sat:8'd0,   ovf_sat:1'b0, max_gap:0};
    vecs[3] = '{c2:8'd255, c1:8'd255, c0:8'd255, x:8'd1,   y_wrap:8'd253, y_sat:8'd255, ovf_sat:1'b1, max_gap:0};
    vecs[4] = '{c2:8'd1,   c1:8'd0,   c0:8'd0,   x:8'd16,  y_wrap:8'd0,   y_sat:8'd255, ovf_sat:1'b1, max_gap:1};
    vecs[5] = '{c2:8'd0,   c1:8'd1,   c0:8'd0,   x:8'd200, y_wrap:8'd200, y_sat:8'd200, ovf_sat:1'b0, max_gap:0};
    vecs[6] = '{c2:8'd3,   c1:8'd7,   c0:8'd11,  x:8'd9,   y_wrap:8'd61,  y_sat:8'd255, ovf_sat:1'b1, max_gap:2};
    vecs[7] = '{c2:8'd1,   c1:8'd1,   c0:8'd1,   x:8'd3,   y_wrap:8'd13,  y_sat:8'd13,  ovf_sat:1'b0, max_gap:3};
    d3_words = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd10};

    reset = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    d3_in_data = '0; d3_in_valid = 1'b0; d3_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_overflow",  32'(overflow),  32'd0);

    for (int i = 0; i < 8; i++) begin
      eval($sformatf("vec%0d", i), vecs[i].c2, vecs[i].c1, vecs[i].c0, vecs[i].x,
           SAT ? vecs[i].y_sat : vecs[i].y_wrap, SAT ? vecs[i].ovf_sat : 1'b0,
           vecs[i].max_gap, 0);
    end

    // Back-pressure: result must stay put for 10 stalled cycles.
    eval("backpressure", 8'd2, 8'd3, 8'd4, 8'd5, 8'd69, 1'b0, 0, 10);

    // Reset during LOAD must discard the words already taken.
    send_word(8'd9, 0);
    send_word(8'd9, 0);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    eval("after_load_rst", 8'd0, 8'd0, 8'd7, 8'd9, 8'd7, 1'b0, 0, 0);

    // Reset while in ADD.
    load_all(8'd2, 8'd3, 8'd4, 8'd5, 0);
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    check("midrst_out_data",  32'(out_data),  32'd0);
    eval("after_mid_rst", 8'd0, 8'd0, 8'd7, 8'd9, 8'd7, 1'b0, 0, 0);

    // Degree-3, 16-bit instance: 1*1000 + 2*100 + 3*10 + 4.
    for (int w = 0; w < 5; w++) begin
      check($sformatf("d3_in_ready_w%0d", w), 32'(d3_in_ready), 32'd1);
      d3_in_data  = d3_words[w];
      d3_in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    d3_in_valid = 1'b0;
    lat = 0;
    while (!d3_out_valid && lat < 30) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    check("d3_latency",  32'(lat),         32'd6);
    check("d3_out_data", 32'(d3_out_data), 32'd1234);
    check("d3_overflow", 32'(d3_overflow), 32'd0);
    d3_out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    d3_out_ready = 1'b0;
    check("d3_release_in_ready", 32'(d3_in_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/poly_horner_engine.md
Name: poly_horner_engine

Overview:
- Parametrised successor to the fixed 8-bit quadratic datapath.
- Evaluates an unsigned polynomial y = c[D]*x^D + ... + c[1]*x + c[0] of configurable degree and width using Horner's rule.
- Uses one shared add/multiply ALU, sequenced by an internal FSM.
- Operands stream in over a valid/ready port; the result leaves over a valid/ready port with back-pressure.

Parameters:
- WIDTH, 8, data/coefficient/result width in bits.
- DEGREE, 2, polynomial degree (>=1).
- CNT_W, $clog2(DEGREE+2), width of the load/step counters.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  operand word: coefficients c[DEGREE] down to c[0], then x.
- in_valid  input  1  in_data valid.
- in_ready  output  1  engine accepts a word this cycle.
- out_data  output  WIDTH  evaluated y.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts result.
- overflow  output  1  some intermediate op exceeded WIDTH bits in the current result (tied 0 unless POLY_SAT_EN).

Behaviour:
- Reset: synchronous, active-high, on clk rising edge.
  - Outputs after reset: in_ready=1, out_valid=0, out_data=0, overflow=0.
  - FSM goes to LOAD; counters and the coefficient array clear to 0.
  - Reset mid-operation discards all partial data.
- Transfer rule: a word transfers when in_valid && in_ready at a rising edge. Same rule for out_valid && out_ready.
- FSM states: LOAD -> MUL -> ADD -> (MUL ... ) -> DONE -> LOAD.
- LOAD:
  - in_ready=1.
  - The k-th accepted word (k=0..DEGREE) is stored to coef[DEGREE-k]; word k=DEGREE+1 is stored to x.
  - On acceptance of x: acc <= coef[DEGREE], step <= DEGREE-1, go to MUL.
  - Gaps in in_valid are allowed; the count holds.
- MUL: acc <= acc*x (truncated to WIDTH bits); go to ADD.
- ADD:
  - acc <= acc + coef[step] (truncated).
  - If step==0, go to DONE; else step <= step-1 and go to MUL.
- DONE:
  - out_valid=1 and out_data=acc, held stable until the out_ready handshake.
  - On handshake, go to LOAD next cycle.
  - in_ready=0 in MUL, ADD and DONE.
- Latency: x accepted at edge N -> out_valid high after edge N+2*DEGREE (N+4 for the default). Best-case throughput is one result per DEGREE+2+2*DEGREE+1 cycles.
- Arithmetic:
  - Unsigned, modulo 2^WIDTH.
  - The multiplier computes a 2*WIDTH product internally; the upper half is used only for overflow/saturation.
- out_data is registered and does not change while out_valid=1.
- overflow is registered, updates only when out_valid rises, and clears on reset.

Optional Feature:
- Macro: POLY_SAT_EN.
- Defined:
  - Each MUL/ADD result saturates to 2^WIDTH-1 when the true result exceeds WIDTH bits.
  - overflow=1 with the result if any step saturated; the sticky flag clears in LOAD.
- Undefined:
  - Wrap-around arithmetic; overflow tied to 0.
  - No saturation logic synthesised.

Decomposition:
- Package poly_pkg:
  - state_t enum {LOAD, MUL, ADD, DONE}.
  - alu_op_t enum {ALU_ADD, ALU_MUL}.
- Sub-module poly_alu (combinational):
  - Inputs: a, b, op.
  - Outputs: WIDTH-bit result and a carry/overflow bit.
  - Saturation is selected by POLY_SAT_EN inside it.
- Top module holds the FSM, coefficient register array, x, acc and the handshake logic.

Test Plan:
- Basic evaluation: WIDTH=8, DEGREE=2, words 2,3,4,x=5 -> out_data=69 (0x45), overflow=0, out_valid exactly 4 cycles after x accepted.
- Wrap vs saturate: words 10,0,0,x=10 -> without POLY_SAT_EN out_data=232 (0xE8), overflow=0; with it out_data=255, overflow=1.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid -> out_data stable, in_ready=0 throughout; release -> next cycle in_ready=1.
- Input gaps: insert random in_valid=0 bubbles during load of 1,1,1,x=3 -> result 13, unaffected by gaps.
- Reset mid-compute: assert reset in the ADD state -> next cycle out_valid=0, in_ready=1. A fresh load 0,0,7,x=9 -> result 7.
- Degree sweep: DEGREE=3, WIDTH=16, words 1,2,3,4,x=10 -> out_data=1234, latency 6 cycles.
